// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
// HPI_RR_ARB_EN selects round-robin arbitration in hpi_arbiter2.
package hpi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } hpi_state_t;

    // HPI register selects presented on OTG_ADDR
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam logic REQ_NIOS    = 1'b0;
    localparam logic REQ_KEYPOLL = 1'b1;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 2;

    function automatic int unsigned hpi_max4(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hpi_arbiter2.sv
// Two-requester grant logic: fixed priority by default, round-robin
// when HPI_RR_ARB_EN is defined.
module hpi_arbiter2
    import hpi_pkg::*;
(
`ifdef HPI_RR_ARB_EN
    input  logic       Clk,
    input  logic       Reset,
    input  logic       accept,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_idx
);

`ifdef HPI_RR_ARB_EN
    logic last_gnt;

    // On a tie the requester that did not win last time is served
    always_comb begin
        grant_idx = REQ_NIOS;
        if (req == 2'b11)
            grant_idx = ~last_gnt;
        else
            grant_idx = req[1] & ~req[0];
        grant = (req == 2'b00) ? 2'b00 : 2'(2'b01 << grant_idx);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            last_gnt <= REQ_KEYPOLL;
        else if (accept)
            last_gnt <= grant_idx;
    end
`else
    always_comb begin
        grant_idx = req[1] & ~req[0];
        grant     = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule

// File: rtl/hpi_bus_sequencer.sv
// Owns the CY7C67200 HPI pins and turns each granted request into a timed
// setup/strobe/hold/recovery access. Optional macro: HPI_RR_ARB_EN.
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            busy,
    output logic [ADDR_W-1:0]               OTG_ADDR,
    output logic                            OTG_CS_N,
    output logic                            OTG_RD_N,
    output logic                            OTG_WR_N,
    output logic [DATA_W-1:0]               OTG_DATA_OUT,
    output logic                            OTG_DATA_OE,
    input  logic [DATA_W-1:0]               OTG_DATA_IN
);

    localparam int unsigned MAX_CYC = hpi_max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    hpi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             cur_write;
    logic [1:0]       grant;
    logic             grant_idx;
    logic             idle_c;
    logic             accept;

    // Ready is forced low while Reset is asserted so it matches its reset value
    assign idle_c    = (state == IDLE) && !Reset;
    assign accept    = idle_c && (req_valid != '0);
    assign req_ready = grant & {NUM_REQ{idle_c}};

    hpi_arbiter2 u_arb (
`ifdef HPI_RR_ARB_EN
        .Clk       (Clk),
        .Reset     (Reset),
        .accept    (accept),
`endif
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State, counter and pin registers; each transition loads the next
    // state's pin values so the pins change exactly on state entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= REQ_NIOS;
            cur_write    <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            OTG_ADDR     <= '0;
            OTG_CS_N     <= 1'b1;
            OTG_RD_N     <= 1'b1;
            OTG_WR_N     <= 1'b1;
            OTG_DATA_OUT <= '0;
            OTG_DATA_OE  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SETUP;
                        cnt          <= CNT_W'(SETUP_CYC);
                        owner        <= grant_idx;
                        cur_write    <= req_write[grant_idx];
                        busy         <= 1'b1;
                        OTG_CS_N     <= 1'b0;
                        OTG_ADDR     <= req_addr[grant_idx];
                        OTG_DATA_OUT <= req_wdata[grant_idx];
                        OTG_DATA_OE  <= req_write[grant_idx];
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(1)) begin
                        state    <= STROBE;
                        cnt      <= CNT_W'(STROBE_CYC);
                        OTG_RD_N <= cur_write;
                        OTG_WR_N <= ~cur_write;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!cur_write)
                            rsp_rdata <= OTG_DATA_IN;
                        state    <= HOLD;
                        cnt      <= CNT_W'(HOLD_CYC);
                        OTG_RD_N <= 1'b1;
                        OTG_WR_N <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(1)) begin
                        state            <= RECOVER;
                        cnt              <= CNT_W'(RECOVERY_CYC);
                        OTG_CS_N         <= 1'b1;
                        OTG_DATA_OE      <= 1'b0;
                        rsp_valid[owner] <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    OTG_CS_N    <= 1'b1;
                    OTG_RD_N    <= 1'b1;
                    OTG_WR_N    <= 1'b1;
                    OTG_DATA_OE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hpi_bus_sequencer.md
Name: hpi_bus_sequencer

Overview:
- Owns the CY7C67200 host-port interface (HPI) pins.
- Arbitrates between two 16-bit requesters: requester 0 is the Nios-side otg_hpi PIO bridge; requester 1 is the hardware keycode poller.
- Expands each granted access into a timed setup/strobe/hold/recovery sequence.
- Captures read data and returns it to the owning requester.

Parameters:
- SETUP_CYC, 1, cycles CS_N/address/data are valid before the strobe falls (min 1)
- STROBE_CYC, 4, cycles RD_N or WR_N is held low (min 1)
- HOLD_CYC, 1, cycles CS_N/address/data are held after the strobe rises (min 1)
- RECOVERY_CYC, 2, cycles CS_N is high before the next access (min 1)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester access request
- req_ready  out  2  per-requester accept; valid&&ready completes the handshake
- req_write  in  2  per-requester direction: 1 = write, 0 = read
- req_addr  in  2x2  per-requester HPI register select
- req_wdata  in  2x16  per-requester write data
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_rdata  out  16  read data, shared; valid when either rsp_valid bit is high
- busy  out  1  high whenever the state is not IDLE
- OTG_ADDR  out  2  HPI address
- OTG_CS_N  out  1  chip select, active low
- OTG_RD_N  out  1  read strobe, active low
- OTG_WR_N  out  1  write strobe, active low
- OTG_DATA_OUT  out  16  write data to the pad
- OTG_DATA_OE  out  1  pad output enable
- OTG_DATA_IN  in  16  data from the pad

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, OTG_CS_N=1, OTG_RD_N=1, OTG_WR_N=1, OTG_DATA_OE=0, OTG_ADDR=0, OTG_DATA_OUT=0. State is IDLE.
- Clocking: one clock (Clk). Reset is asynchronous and active-high. It returns every state and output to its reset value immediately, including mid-access. An access aborted by reset never produces rsp_valid.
- Handshake:
  - A requester holds req_valid and its fields stable until it sees req_ready.
  - req_ready is combinational: asserted only in IDLE, only for the granted requester.
  - Fields are latched on the accept cycle.
- Arbitration: fixed priority; requester 0 wins when both are valid.
- States:
  - IDLE: on accept, go to SETUP (counter=SETUP_CYC).
  - SETUP: CS_N=0; ADDR driven; OE=write; DATA_OUT=wdata; strobes high.
  - STROBE: as SETUP, plus RD_N=0 for a read or WR_N=0 for a write, for STROBE_CYC cycles. On the final STROBE cycle a read registers OTG_DATA_IN.
  - HOLD: strobes high; CS_N, ADDR and OE/data still held, for HOLD_CYC cycles.
  - RECOVER: CS_N=1, OE=0, for RECOVERY_CYC cycles, then IDLE.
- Response: rsp_valid[owner] pulses on the first RECOVER cycle. rsp_rdata holds the captured value until the next read capture. Writes also pulse rsp_valid; rsp_rdata is unchanged.
- Latency: with the accept at cycle 0, rsp_valid is at cycle SETUP+STROBE+HOLD+1 (default 7). The earliest next accept is cycle SETUP+STROBE+HOLD+RECOVERY+1 (default 9).
- Strobe exclusivity: RD_N and WR_N are never low simultaneously. No strobe is low while CS_N is high.
- Exclusivity: at most one rsp_valid bit is high at a time.
- Requests during an access: a req_valid that rises during a non-IDLE state waits. Dropping req_valid before ready is a protocol violation and leaves the sequencer unaffected.
- Counter: a single down-counter, width $clog2 of the maximum parameter + 1, reloaded on each state entry.

Optional Feature:
- HPI_RR_ARB_EN defined:
  - Two-way round-robin arbitration.
  - A last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates on each accept.
- HPI_RR_ARB_EN undefined: fixed priority, requester 0 over requester 1. No pointer register.

Decomposition:
- hpi_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - HPI register constants: HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3;
  - the requester-index constants.
- Sub-module hpi_arbiter2: grant logic, containing both the fixed and round-robin variants under the macro.

Test Plan:
- Single write: req0 write addr=2, wdata=16'h1234, default parameters.
  - CS_N low cycles 1-6, WR_N low cycles 2-5, OE=1 cycles 1-6, DATA_OUT=1234 throughout.
  - rsp_valid[0] at cycle 7; req_ready[0] next possible at cycle 9.
- Single read: req1 read addr=0, OTG_DATA_IN=16'hBEEF during the strobe.
  - RD_N low cycles 2-5, OE=0 throughout.
  - rsp_valid[1] at cycle 7 with rsp_rdata=BEEF; WR_N stays high throughout.
- Simultaneous requests, fixed priority: both valid at cycle 0.
  - req0 is served first; req1 is accepted at cycle 9 with rsp_valid[1] at cycle 16.
  - With HPI_RR_ARB_EN and a back-to-back repeat, grant order is 0,1,0,1.
- Reset mid-strobe: assert Reset at cycle 3 of a read.
  - CS_N, RD_N and WR_N go to 1 and OE to 0 the same cycle; no rsp_valid.
  - After release, a new request is accepted immediately in IDLE.
- Parameter sweep: SETUP=2, STROBE=1, HOLD=3, RECOVERY=1.
  - rsp_valid at cycle 7; next accept at cycle 8.
  - CS_N/strobe relation holds on every cycle.
